// File: rtl/autobaud_sync.sv
// Auto-baud / auto-parity detector: times a 0x55,0x57 sync pair, samples the
// parity/stop slot of each, then publishes an oversampling divisor and parity mode.
module autobaud_sync #(
  parameter int CNT_W     = 20,
  parameter int OVS_LOG2  = 4,
  parameter int DVSR_W    = 12,
  parameter int TOL_SHIFT = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              rx,
  output logic [DVSR_W-1:0] baud_dvsr,
  output logic [CNT_W-1:0]  bit_period,
  output logic [1:0]        parity_mode,
  output logic              busy,
  output logic              locked,
  output logic              done_tick,
  output logic              err_tick
);

  typedef enum logic [2:0] {S_IDLE, S_HUNT, S_MEAS, S_PAR, S_GAP, S_CHECK} state_t;

  state_t            state, nxt;
  logic              rx_m, rx_s, rx_s_d, fe;
  logic [CNT_W-1:0]  cnt, span0, span1, span_cur, par_pt, diff, tol;
  logic [2:0]        ecnt;
  logic              idx;
  logic [1:0]        p;
  logic [CNT_W:0]    sum, avg, dv;
  logic              cnt_max, edge_last, par_hit, dv_big, check_ok, timing_st;
  logic [1:0]        pmode;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_m   <= 1'b1;
      rx_s   <= 1'b1;
      rx_s_d <= 1'b1;
    end else begin
      rx_m   <= rx;
      rx_s   <= rx_m;
      rx_s_d <= rx_s;
    end
  end

  assign fe        = rx_s_d & ~rx_s;
  assign cnt_max   = (cnt == '1);
  assign span_cur  = idx ? span1 : span0;
  assign par_pt    = (span_cur >> 3) + (span_cur >> 4);
  assign par_hit   = (cnt == par_pt);
  // 0x57 has no b1 edge, so its b7 edge is the 3rd after start; 0x55's is the 4th
  assign edge_last = fe && (ecnt == (idx ? 3'd2 : 3'd3));
  assign timing_st = (state == S_MEAS) || (state == S_PAR) || (state == S_GAP);

  assign sum      = {1'b0, span0} + {1'b0, span1};
  assign avg      = sum >> 1;
  assign dv       = avg >> (3 + OVS_LOG2);
  assign dv_big   = |(dv >> DVSR_W);
  assign diff     = (span0 >= span1) ? (span0 - span1) : (span1 - span0);
  assign tol      = span0 >> TOL_SHIFT;
  assign check_ok = (diff <= tol) && (p != 2'b00) && (dv != '0);
  // p[0]=0,p[1]=1 -> even; p[0]=1,p[1]=0 -> odd; both high means stop bits only
  assign pmode    = (p == 2'b11) ? 2'd0 : (p == 2'b10) ? 2'd2 : 2'd1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= nxt;
  end

  always_comb begin
    nxt = state;
    if (start) nxt = S_HUNT;
    else begin
      case (state)
        S_IDLE:  nxt = S_IDLE;
        S_HUNT:  if (fe) nxt = S_MEAS;
        S_MEAS:  if (cnt_max) nxt = S_HUNT; else if (edge_last) nxt = S_PAR;
        S_PAR:   if (cnt_max) nxt = S_HUNT; else if (par_hit) nxt = idx ? S_CHECK : S_GAP;
        S_GAP:   if (cnt_max) nxt = S_HUNT; else if (fe) nxt = S_MEAS;
        S_CHECK: nxt = check_ok ? S_IDLE : S_HUNT;
        default: nxt = S_IDLE;
      endcase
    end
  end

  always_comb begin
    busy      = (state != S_IDLE);
    done_tick = 1'b0;
    err_tick  = 1'b0;
    if (!start) begin
      done_tick = (state == S_CHECK) && check_ok;
      err_tick  = ((state == S_CHECK) && !check_ok) || (timing_st && cnt_max);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt         <= '0;
      ecnt        <= '0;
      idx         <= 1'b0;
      span0       <= '0;
      span1       <= '0;
      p           <= '0;
      baud_dvsr   <= '0;
      bit_period  <= '0;
      parity_mode <= '0;
      locked      <= 1'b0;
    end else if (start) begin
      cnt   <= '0;
      ecnt  <= '0;
      idx   <= 1'b0;
      span0 <= '0;
      span1 <= '0;
      p     <= '0;
    end else begin
      case (state)
        S_HUNT: begin
          idx <= 1'b0;
          if (fe) begin
            cnt  <= CNT_W'(1);
            ecnt <= '0;
          end
        end
        S_MEAS: begin
          cnt <= cnt + 1'b1;
          if (fe) ecnt <= ecnt + 1'b1;
          if (edge_last) begin
            if (idx) span1 <= cnt;
            else     span0 <= cnt;
            cnt <= '0;
          end
        end
        S_PAR: begin
          cnt <= cnt + 1'b1;
          if (par_hit) begin
            p[idx] <= rx_s;
            if (!idx) cnt <= '0;
          end
        end
        S_GAP: begin
          cnt <= cnt + 1'b1;
          if (fe) begin
            idx  <= 1'b1;
            cnt  <= CNT_W'(1);
            ecnt <= '0;
          end
        end
        S_CHECK: begin
          if (check_ok) begin
            bit_period  <= CNT_W'(avg >> 3);
            baud_dvsr   <= dv_big ? '1 : DVSR_W'(dv);
            parity_mode <= pmode;
            locked      <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_autobaud_sync.sv
// Randomised sync-pair bench for autobaud_sync with a per-cycle output scoreboard.
module tb_autobaud_sync;
  localparam int CNT_W = 13, OVS_LOG2 = 4, DVSR_W = 12, TOL_SHIFT = 4;

  logic              clk = 1'b0, rst_n = 1'b0, start = 1'b0, rx = 1'b1;
  logic [DVSR_W-1:0] baud_dvsr;
  logic [CNT_W-1:0]  bit_period;
  logic [1:0]        parity_mode;
  logic              busy, locked, done_tick, err_tick;

  autobaud_sync #(.CNT_W(CNT_W), .OVS_LOG2(OVS_LOG2), .DVSR_W(DVSR_W), .TOL_SHIFT(TOL_SHIFT)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .rx(rx),
    .baud_dvsr(baud_dvsr), .bit_period(bit_period), .parity_mode(parity_mode),
    .busy(busy), .locked(locked), .done_tick(done_tick), .err_tick(err_tick)
  );

  always #5 clk = ~clk;

  int n_total = 0, n_pass = 0, n_fail = 0;
  int done_cnt = 0, err_cnt = 0;
  int m_dvsr = 0, m_bp = 0, m_pm = 0, m_locked = 0;
  int pend_dvsr = 0, pend_bp = 0, pend_pm = 0;

  task automatic check(string name, int got, int exp);
    n_total++;
    if (got == exp) n_pass++;
    else begin
      n_fail++;
      if (n_fail <= 30) $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask

  // published outputs only move one cycle after done_tick, or on reset
  always @(negedge clk) begin
    if (!rst_n) begin
      m_dvsr = 0; m_bp = 0; m_pm = 0; m_locked = 0;
    end
    check("baud_dvsr",   int'(baud_dvsr),   m_dvsr);
    check("bit_period",  int'(bit_period),  m_bp);
    check("parity_mode", int'(parity_mode), m_pm);
    check("locked",      int'(locked),      m_locked);
    if (!rst_n) begin
      check("done_in_rst", int'(done_tick), 0);
      check("err_in_rst",  int'(err_tick),  0);
    end else begin
      if (done_tick) begin
        done_cnt++;
        m_dvsr = pend_dvsr; m_bp = pend_bp; m_pm = pend_pm; m_locked = 1;
      end
      if (err_tick) err_cnt++;
    end
  end

  task automatic tick(int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic pulse_start();
    start = 1'b1; tick(1); start = 1'b0;
  endtask

  task automatic send_char(input logic [7:0] c, input int t, input bit hp, input bit pb);
    rx = 1'b0; tick(t);
    for (int i = 0; i < 8; i++) begin rx = c[i]; tick(t); end
    if (hp) begin rx = pb; tick(t); end
    rx = 1'b1; tick(t);
  endtask

  // Reference: spans are 8T, the slot after b7 is parity or (no parity) stop=1.
  task automatic do_pair(input int t1, input int t2, input bit hp, input bit pb0, input bit pb1,
                         input int gap, input bit arm, output bit ok);
    int s0, s1, df, avg, dv, p0, p1, d0, e0;
    s0 = 8 * t1; s1 = 8 * t2;
    df = (s0 > s1) ? s0 - s1 : s1 - s0;
    avg = (s0 + s1) / 2;
    dv = avg / (8 << OVS_LOG2);
    p0 = hp ? int'(pb0) : 1;
    p1 = hp ? int'(pb1) : 1;
    ok = (df <= (s0 >> TOL_SHIFT)) && (p0 + p1 > 0) && (dv != 0);
    pend_dvsr = (dv > (1 << DVSR_W) - 1) ? (1 << DVSR_W) - 1 : dv;
    pend_bp = avg / 8;
    pend_pm = (p0 == 1 && p1 == 1) ? 0 : (p1 == 1) ? 2 : 1;
    d0 = done_cnt; e0 = err_cnt;
    if (arm) begin
      pulse_start();
      check("busy_after_start", int'(busy), 1);
    end
    rx = 1'b1; tick(2);
    send_char(8'h55, t1, hp, pb0);
    tick(gap);
    send_char(8'h57, t2, hp, pb1);
    tick(5);
    check("done_pulses", done_cnt - d0, ok ? 1 : 0);
    check("err_pulses",  err_cnt - e0,  ok ? 0 : 1);
    check("busy_after",  int'(busy),    ok ? 0 : 1);
  endtask

  initial begin
    bit ok;
    int n, e0, d0, t1, t2;
    tick(3);
    check("rst_dvsr", int'(baud_dvsr), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_locked", int'(locked), 0);
    rst_n = 1'b1; tick(3);

    // even parity, T=434: bits 0 then 1
    do_pair(434, 434, 1, 0, 1, 10, 1, ok);
    tick(1);
    check("even_dvsr", int'(baud_dvsr), 27);
    check("even_bp", int'(bit_period), 434);
    check("even_pm", int'(parity_mode), 2);
    check("even_locked", int'(locked), 1);

    // odd parity
    do_pair(434, 434, 1, 1, 0, 3, 1, ok);
    tick(1);
    check("odd_pm", int'(parity_mode), 1);
    check("odd_dvsr", int'(baud_dvsr), 27);

    // no parity, T=54
    do_pair(54, 54, 0, 0, 0, 5, 1, ok);
    tick(1);
    check("none_pm", int'(parity_mode), 0);
    check("none_bp", int'(bit_period), 54);
    check("none_dvsr", int'(baud_dvsr), 3);

    // mismatch 434 vs 470, then recovery without a new start
    do_pair(434, 470, 1, 0, 1, 4, 1, ok);
    check("mismatch_expect_fail", int'(ok), 0);
    check("mismatch_keeps_bp", int'(bit_period), 54);
    do_pair(60, 61, 1, 0, 1, 7, 0, ok);

    // divisor of zero is rejected
    do_pair(12, 12, 1, 0, 1, 2, 1, ok);
    check("dv0_expect_fail", int'(ok), 0);

    // timeout: one falling edge then the line stuck low
    pulse_start(); rx = 1'b1; tick(2);
    rx = 1'b0; e0 = err_cnt; n = 0;
    while (err_cnt == e0 && n < 9000) begin tick(1); n++; end
    check("timeout_seen", err_cnt - e0, 1);
    check("timeout_window", int'(n >= 8185 && n <= 8200), 1);
    check("timeout_busy", int'(busy), 1);

    // restart mid-MEAS, then a pair detected without another start
    rx = 1'b1; tick(5); rx = 1'b0; tick(20); rx = 1'b1; tick(20); rx = 1'b0; tick(20);
    e0 = err_cnt; d0 = done_cnt;
    pulse_start();
    rx = 1'b1; tick(10);
    check("restart_no_err", err_cnt - e0, 0);
    check("restart_no_done", done_cnt - d0, 0);
    do_pair(48, 48, 1, 1, 0, 6, 0, ok);

    // reset while sampling the first character's parity slot
    pulse_start(); rx = 1'b1; tick(2);
    rx = 1'b0; tick(40);
    for (int i = 0; i < 8; i++) begin rx = (i % 2 == 0); tick(40); end
    rx = 1'b0; tick(15);
    rst_n = 1'b0; #1;
    check("rstmid_dvsr", int'(baud_dvsr), 0);
    check("rstmid_pm", int'(parity_mode), 0);
    check("rstmid_busy", int'(busy), 0);
    check("rstmid_locked", int'(locked), 0);
    tick(2); rst_n = 1'b1; rx = 1'b1; tick(40);
    do_pair(40, 40, 1, 0, 1, 3, 1, ok);
    tick(1);
    check("post_rst_dvsr", int'(baud_dvsr), 2);
    check("post_rst_pm", int'(parity_mode), 2);

    // randomised pairs
    for (int k = 0; k < 10; k++) begin
      t1 = $urandom_range(16, 80);
      t2 = t1 + $urandom_range(0, 8) - 4;
      do_pair(t1, t2, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
              1'($urandom_range(0, 1)), $urandom_range(1, 40), 1, ok);
    end

    tick(5);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
